ppm_stream_correlator: RTL and testbench
========================================

# ppm_stream_correlator

Streaming, multi-frame successor to the 16-slot PPM correlator. Chips arrive serially, one slot per accepted beat. They are summed per slot over `NUM_FRAMES` consecutive PPM frames. After the final frame the block emits the winning slot index, its integrated peak value and a threshold flag through a ready/valid output. It sits between the SPAD chip quantiser and the symbol deframer, and adds integration, backpressure and resynchronisation.

## Interface
- `PPM_ORDER`, 4: log2 of slots per frame; M = 2^PPM_ORDER slots.
- `CHIP_BITS`, 3: width of one chip value (unsigned).
- `NUM_FRAMES`, 1: frames integrated per decision, >= 1.
- `ACC_BITS`, CHIP_BITS + $clog2(NUM_FRAMES+1): per-slot accumulator width (unsigned, saturating).

- `clk`  in  1  sole clock, rising edge.
- `rstb`  in  1  asynchronous active-low reset.
- `chip_in`  in  CHIP_BITS  chip value for the current slot.
- `chip_valid`  in  1  chip_in accepted this cycle (the block never stalls input).
- `frame_sync`  in  1  abort and restart: next accepted chip is slot 0, frame 0.
- `corr_threshold`  in  ACC_BITS  minimum integrated peak; sampled on the decision cycle.
- `out_ready`  in  1  downstream accepts the result.
- `out_valid`  out  1  result registers hold a valid decision.
- `symbol`  out  PPM_ORDER  winning slot index.
- `peak_value`  out  ACC_BITS  integrated value of the winning slot.
- `threshold_unmet`  out  1  peak_value < corr_threshold.
- `overrun`  out  1  one-cycle pulse: a decision was dropped because the output was occupied.

## Operation
- Counters: `slot_cnt` (PPM_ORDER bits) and `frame_cnt` ($clog2(NUM_FRAMES) bits, min 1). Both advance only on `chip_valid`. `slot_cnt` wraps M-1 -> 0 and increments `frame_cnt`. `frame_cnt` wraps NUM_FRAMES-1 -> 0.
- State `ACCUM` (frame_cnt < NUM_FRAMES-1): `acc[slot] <= (frame_cnt==0) ? chip_in : sat(acc[slot]+chip_in)`. Frame 0 overwrites, so no clear cycle is needed.
- State `DECIDE` (final frame): same update, plus a running max over the updated value. Strict `>` compare, so ties go to the lowest slot index. The max register is loaded unconditionally at slot 0.
- Saturation: the sum clamps to 2^ACC_BITS-1.
- When NUM_FRAMES=1 the block stays in `DECIDE` every frame.
- Decision event: accept of slot M-1 while in `DECIDE`.
  - If `out_valid`=0, or `out_valid`&&`out_ready` in the same cycle: load `symbol`, `peak_value`, `threshold_unmet` and set `out_valid`.
  - Else: keep the old result and pulse `overrun`.
- `out_valid` clears on `out_valid && out_ready` unless a new decision loads in that same cycle.
- `frame_sync`:
  - Resets `slot_cnt`, `frame_cnt` and the running max. Partial integration is discarded and no decision is made.
  - If it coincides with `chip_valid`, that chip is taken as slot 0, frame 0.
  - Output registers and `out_valid` are unaffected.
- `corr_threshold` and results change only on the decision edge.

## Timing
- Reset values: `out_valid`=0, `symbol`=0, `peak_value`=0, `threshold_unmet`=1, `overrun`=0. Counters and running max are 0. Accumulator contents are don't-care.
- Latency: the decision is visible on the rising edge after the cycle in which slot M-1 of the final frame is accepted (1 cycle).
- Throughput: one chip per cycle, sustained, with back-to-back integrations. A result is held until accepted.
- `rstb` assertion mid-integration: everything returns to reset values immediately. The first chip accepted after deassertion is slot 0, frame 0.
- Gaps in `chip_valid` only pause the counters and have no other effect.

## Test plan
- M=16, NUM_FRAMES=1, threshold 2, `out_ready`=1. Stream slots 0..15 = 0,0,0,0,6,3,2,1,0,0,1,2,5,4,3,2. Expect `symbol`=4, `peak_value`=6, `threshold_unmet`=0, `out_valid` for 1 cycle, one cycle after slot 15.
- Same stream with threshold 7 -> `symbol`=4, `peak_value`=6, `threshold_unmet`=1.
- Tie case: slots 3 and 9 both = 5, all others 0. Expect `symbol`=3.
- NUM_FRAMES=4, ACC_BITS=4.
  - Slot 7 = 7 in every frame, others 1. Expect `symbol`=7, `peak_value`=15 (saturated).
  - Same with ACC_BITS=6: expect `peak_value`=28.
- Backpressure: `out_ready`=0 across two consecutive NUM_FRAMES=1 decisions. Expect the first result to be held, `overrun` to pulse once at the second decision, and `out_valid` to clear after `out_ready` rises.
- `frame_sync` asserted at slot 8, then a fresh 16-slot frame with peak at slot 2. Expect exactly one decision, `symbol`=2. Also assert `rstb` mid-frame and expect all outputs at reset values.

Source files
------------

// File: rtl/ppm_stream_correlator.sv
// -----------------------------------------------------------------------------
// ppm_stream_correlator
//
// Streaming multi-frame PPM correlator. Serial chips (one slot per accepted
// beat) are summed per slot over NUM_FRAMES consecutive PPM frames in a
// saturating accumulator bank. During the final frame a running maximum
// tracks the winning slot; when slot M-1 of the final frame is accepted the
// winner is registered into a ready/valid result holding slot.
//
// Ports
//   clk             sole clock, rising edge
//   rstb            asynchronous active-low reset
//   chip_in         chip value for the current slot (unsigned)
//   chip_valid      chip_in is accepted this cycle (input never stalls)
//   frame_sync      abort integration; next accepted chip is slot 0, frame 0
//   corr_threshold  minimum integrated peak, sampled on the decision cycle
//   out_ready       downstream accepts the held result
//   out_valid       result registers hold a valid decision
//   symbol          winning slot index
//   peak_value      integrated value of the winning slot
//   threshold_unmet peak_value < corr_threshold
//   overrun         one-cycle pulse: a decision was dropped (output occupied)
// -----------------------------------------------------------------------------
module ppm_stream_correlator #(
  parameter int PPM_ORDER  = 4,
  parameter int CHIP_BITS  = 3,
  parameter int NUM_FRAMES = 1,
  parameter int ACC_BITS   = CHIP_BITS + $clog2(NUM_FRAMES + 1)
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic [CHIP_BITS-1:0] chip_in,
  input  logic                 chip_valid,
  input  logic                 frame_sync,
  input  logic [ACC_BITS-1:0]  corr_threshold,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [PPM_ORDER-1:0] symbol,
  output logic [ACC_BITS-1:0]  peak_value,
  output logic                 threshold_unmet,
  output logic                 overrun
);

  localparam int M    = 1 << PPM_ORDER;
  localparam int FC_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam logic [PPM_ORDER-1:0] SLOT_MAX   = '1;
  localparam logic [FC_W-1:0]      FRAME_LAST = FC_W'(NUM_FRAMES - 1);

  // The integration phase is a pure decode of the frame counter.
  typedef enum logic {ACCUM, DECIDE} state_e;

  // Registers
  logic [PPM_ORDER-1:0] r_slot_cnt;
  logic [FC_W-1:0]      r_frame_cnt;
  logic [ACC_BITS-1:0]  r_max_val;
  logic [PPM_ORDER-1:0] r_max_slot;
  logic [ACC_BITS-1:0]  r_acc [M];
  logic                 r_out_valid;
  logic [PPM_ORDER-1:0] r_symbol;
  logic [ACC_BITS-1:0]  r_peak;
  logic                 r_unmet;
  logic                 r_overrun;

  // Combinational datapath
  logic [PPM_ORDER-1:0] w_slot_eff;
  logic [FC_W-1:0]      w_frame_eff;
  state_e               w_state;
  logic [ACC_BITS:0]    w_sum;
  logic [ACC_BITS-1:0]  w_sat;
  logic [ACC_BITS-1:0]  w_acc_new;
  logic                 w_take;
  logic [ACC_BITS-1:0]  w_win_val;
  logic [PPM_ORDER-1:0] w_win_slot;
  logic                 w_decision;
  logic                 w_load;

  // NOTE: combinational logic uses blocking '=' with every output assigned on
  // every path, so no latch can be inferred; clocked state below uses '<='.
  always_comb begin
    // frame_sync forces the current beat (if any) to slot 0, frame 0.
    w_slot_eff  = frame_sync ? '0 : r_slot_cnt;
    w_frame_eff = frame_sync ? '0 : r_frame_cnt;
    w_state     = (w_frame_eff == FRAME_LAST) ? DECIDE : ACCUM;

    // Saturating add; frame 0 overwrites so no clear cycle is needed.
    w_sum     = {1'b0, r_acc[w_slot_eff]} + (ACC_BITS + 1)'(chip_in);
    w_sat     = w_sum[ACC_BITS] ? '1 : w_sum[ACC_BITS-1:0];
    w_acc_new = (w_frame_eff == '0) ? ACC_BITS'(chip_in) : w_sat;

    // Slot 0 seeds the max unconditionally; strict '>' keeps the lowest
    // index on ties.
    w_take     = (w_slot_eff == '0) || (w_acc_new > r_max_val);
    w_win_val  = w_take ? w_acc_new  : r_max_val;
    w_win_slot = w_take ? w_slot_eff : r_max_slot;

    w_decision = chip_valid && (w_state == DECIDE) && (w_slot_eff == SLOT_MAX);
    // The result slot is free if empty or being drained this same cycle.
    w_load     = w_decision && (!r_out_valid || out_ready);
  end

  // Slot / frame counters: advance only on accepted chips.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_slot_cnt  <= '0;
      r_frame_cnt <= '0;
    end else if (chip_valid) begin
      r_slot_cnt <= w_slot_eff + PPM_ORDER'(1);
      if (w_slot_eff == SLOT_MAX) begin
        r_frame_cnt <= (w_frame_eff == FRAME_LAST) ? '0 : w_frame_eff + FC_W'(1);
      end else begin
        r_frame_cnt <= w_frame_eff;
      end
    end else if (frame_sync) begin
      r_slot_cnt  <= '0;
      r_frame_cnt <= '0;
    end
  end

  // Running maximum, only meaningful during the final frame.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_max_val  <= '0;
      r_max_slot <= '0;
    end else if (chip_valid && (w_state == DECIDE)) begin
      r_max_val  <= w_win_val;
      r_max_slot <= w_win_slot;
    end else if (frame_sync) begin
      r_max_val  <= '0;
      r_max_slot <= '0;
    end
  end

  // NOTE: the accumulator bank has no reset; every entry is overwritten in
  // frame 0 before it is read as a partial sum, so a reset would only add
  // routing to a RAM-like structure.
  always_ff @(posedge clk) begin
    if (chip_valid) begin
      r_acc[w_slot_eff] <= w_acc_new;
    end
  end

  // Result holding registers with ready/valid handshake and overrun pulse.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_out_valid <= 1'b0;
      r_symbol    <= '0;
      r_peak      <= '0;
      r_unmet     <= 1'b1;
      r_overrun   <= 1'b0;
    end else begin
      r_overrun <= w_decision && !w_load;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_symbol    <= w_win_slot;
        r_peak      <= w_win_val;
        r_unmet     <= (w_win_val < corr_threshold);
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid       = r_out_valid;
  assign symbol          = r_symbol;
  assign peak_value      = r_peak;
  assign threshold_unmet = r_unmet;
  assign overrun         = r_overrun;

endmodule

// File: tb/tb_ppm_stream_correlator.sv
// -----------------------------------------------------------------------------
// tb_ppm_stream_correlator
//
// Three correlator instances:
//   u_a : NUM_FRAMES=1 (ACC_BITS 4)  - single-frame decisions, backpressure,
//                                      frame_sync and mid-frame reset
//   u_b : NUM_FRAMES=4, ACC_BITS=4   - multi-frame integration with saturation
//   u_c : NUM_FRAMES=4, ACC_BITS=6   - same stream as u_b, no saturation
// Stimulus pushes hand-computed results into per-instance queues; monitors
// pop and compare whenever a result is handed over (out_valid && out_ready).
// -----------------------------------------------------------------------------
module tb_ppm_stream_correlator;

  typedef struct packed {
    logic [3:0] sym;
    logic [7:0] peak;
    logic       unmet;
  } exp_t;

  logic clk;
  logic rstb;

  // Instance A signals
  logic [2:0] a_chip;
  logic       a_valid, a_sync, a_ready;
  logic [3:0] a_thr;
  logic       a_ov, a_unmet, a_overrun;
  logic [3:0] a_sym, a_peak;

  // Instances B/C share one input stream
  logic [2:0] bc_chip;
  logic       bc_valid, bc_sync, bc_ready;
  logic [3:0] b_thr;
  logic [5:0] c_thr;
  logic       b_ov, b_unmet, b_overrun;
  logic [3:0] b_sym, b_peak;
  logic       c_ov, c_unmet, c_overrun;
  logic [3:0] c_sym;
  logic [5:0] c_peak;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q_a[$], q_b[$], q_c[$];
  exp_t ea, eb, ec;
  int   frame_v[16];

  ppm_stream_correlator #(.PPM_ORDER(4), .CHIP_BITS(3), .NUM_FRAMES(1), .ACC_BITS(4)) u_a (
    .clk(clk), .rstb(rstb), .chip_in(a_chip), .chip_valid(a_valid), .frame_sync(a_sync),
    .corr_threshold(a_thr), .out_ready(a_ready), .out_valid(a_ov), .symbol(a_sym),
    .peak_value(a_peak), .threshold_unmet(a_unmet), .overrun(a_overrun));

  ppm_stream_correlator #(.PPM_ORDER(4), .CHIP_BITS(3), .NUM_FRAMES(4), .ACC_BITS(4)) u_b (
    .clk(clk), .rstb(rstb), .chip_in(bc_chip), .chip_valid(bc_valid), .frame_sync(bc_sync),
    .corr_threshold(b_thr), .out_ready(bc_ready), .out_valid(b_ov), .symbol(b_sym),
    .peak_value(b_peak), .threshold_unmet(b_unmet), .overrun(b_overrun));

  ppm_stream_correlator #(.PPM_ORDER(4), .CHIP_BITS(3), .NUM_FRAMES(4), .ACC_BITS(6)) u_c (
    .clk(clk), .rstb(rstb), .chip_in(bc_chip), .chip_valid(bc_valid), .frame_sync(bc_sync),
    .corr_threshold(c_thr), .out_ready(bc_ready), .out_valid(c_ov), .symbol(c_sym),
    .peak_value(c_peak), .threshold_unmet(c_unmet), .overrun(c_overrun));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int sym, input int peak, input int unmet);
    exp_t e;
    e.sym   = 4'(sym);
    e.peak  = 8'(peak);
    e.unmet = 1'(unmet);
    return e;
  endfunction

  // ---------------- Monitors (scoreboard side) ----------------
  always @(negedge clk) begin
    if (rstb === 1'b1 && a_ov === 1'b1 && a_ready === 1'b1) begin
      if (q_a.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL a_unexpected_result: symbol=%0d peak=%0d, no result expected (t=%0t)",
                 a_sym, a_peak, $time);
      end else begin
        ea = q_a.pop_front();
        check("a_symbol", 32'(a_sym),   32'(ea.sym));
        check("a_peak",   32'(a_peak),  32'(ea.peak));
        check("a_unmet",  32'(a_unmet), 32'(ea.unmet));
      end
    end
  end

  always @(negedge clk) begin
    if (rstb === 1'b1 && b_ov === 1'b1 && bc_ready === 1'b1) begin
      if (q_b.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL b_unexpected_result: symbol=%0d peak=%0d, no result expected (t=%0t)",
                 b_sym, b_peak, $time);
      end else begin
        eb = q_b.pop_front();
        check("b_symbol", 32'(b_sym),   32'(eb.sym));
        check("b_peak",   32'(b_peak),  32'(eb.peak));
        check("b_unmet",  32'(b_unmet), 32'(eb.unmet));
      end
    end
  end

  always @(negedge clk) begin
    if (rstb === 1'b1 && c_ov === 1'b1 && bc_ready === 1'b1) begin
      if (q_c.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL c_unexpected_result: symbol=%0d peak=%0d, no result expected (t=%0t)",
                 c_sym, c_peak, $time);
      end else begin
        ec = q_c.pop_front();
        check("c_symbol", 32'(c_sym),   32'(ec.sym));
        check("c_peak",   32'(c_peak),  32'(ec.peak));
        check("c_unmet",  32'(c_unmet), 32'(ec.unmet));
      end
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < 16; i++) frame_v[i] = v;
  endtask

  // Streams frame_v[0..n-1] into instance A. Optional idle gaps every 4 beats
  // (never after the last beat) and optional frame_sync on the first beat.
  // Returns 1 time unit after the edge that accepted the last chip.
  task automatic send_a(input int n, input bit gap, input bit sync_first);
    for (int i = 0; i < n; i++) begin
      a_chip  = 3'(frame_v[i]);
      a_valid = 1'b1;
      a_sync  = sync_first && (i == 0);
      tick();
      a_sync = 1'b0;
      if (gap && (i % 4 == 3) && (i != n - 1)) begin
        a_valid = 1'b0;
        tick();
      end
    end
    a_valid = 1'b0;
  endtask

  task automatic send_bc(input int n);
    for (int i = 0; i < n; i++) begin
      bc_chip  = 3'(frame_v[i]);
      bc_valid = 1'b1;
      tick();
    end
    bc_valid = 1'b0;
  endtask

  task automatic load_t1();
    frame_v = '{0, 0, 0, 0, 6, 3, 2, 1, 0, 0, 1, 2, 5, 4, 3, 2};
  endtask

  // ---------------- Directed test sequence ----------------
  initial begin
    rstb = 1'b0;
    a_chip = '0; a_valid = 1'b0; a_sync = 1'b0; a_ready = 1'b1; a_thr = 4'd2;
    bc_chip = '0; bc_valid = 1'b0; bc_sync = 1'b0; bc_ready = 1'b1;
    b_thr = 4'd15; c_thr = 6'd29;

    // Reset state
    tick(); tick();
    check("rst_out_valid", 32'(a_ov),      32'd0);
    check("rst_symbol",    32'(a_sym),     32'd0);
    check("rst_peak",      32'(a_peak),    32'd0);
    check("rst_unmet",     32'(a_unmet),   32'd1);
    check("rst_overrun",   32'(a_overrun), 32'd0);
    check("rst_b_unmet",   32'(b_unmet),   32'd1);
    rstb = 1'b1;
    tick();

    // T1: basic frame, threshold met, 1-cycle latency, valid for one cycle
    load_t1();
    a_thr = 4'd2;
    q_a.push_back(mk(4, 6, 0));
    send_a(16, 1'b0, 1'b0);
    check("a_latency_valid", 32'(a_ov), 32'd1);
    tick();
    check("a_valid_one_cycle", 32'(a_ov), 32'd0);

    // T2: same stream, threshold 7, with idle gaps in chip_valid
    a_thr = 4'd7;
    q_a.push_back(mk(4, 6, 1));
    send_a(16, 1'b1, 1'b0);
    check("a_gap_latency_valid", 32'(a_ov), 32'd1);
    tick();

    // T3: tie between slots 3 and 9 -> lowest index; peak equals threshold
    fill(0); frame_v[3] = 5; frame_v[9] = 5;
    a_thr = 4'd5;
    q_a.push_back(mk(3, 5, 0));
    send_a(16, 1'b0, 1'b0);
    tick();

    // T4: all-zero frame -> slot 0 seeds the max, threshold 1 unmet
    fill(0);
    a_thr = 4'd1;
    q_a.push_back(mk(0, 0, 1));
    send_a(16, 1'b0, 1'b0);
    tick();

    // Multi-frame B/C: slot 7 = 7 every frame, others 1
    fill(1); frame_v[7] = 7;
    b_thr = 4'd15; c_thr = 6'd29;
    q_b.push_back(mk(7, 15, 0));
    q_c.push_back(mk(7, 28, 1));
    for (int f = 0; f < 4; f++) send_bc(16);
    check("bc_latency_valid", 32'(b_ov), 32'd1);
    tick();

    // Multi-frame B/C: tie at 12 between slots 2 and 10; frame 0 overwrites
    // the previous integration's slot 7
    fill(0); frame_v[2] = 3; frame_v[10] = 3;
    b_thr = 4'd15; c_thr = 6'd10;
    q_b.push_back(mk(2, 12, 1));
    q_c.push_back(mk(2, 12, 0));
    for (int f = 0; f < 4; f++) send_bc(16);
    tick();

    // Backpressure: two back-to-back decisions with out_ready low
    a_ready = 1'b0;
    a_thr   = 4'd2;
    fill(0); frame_v[5] = 7;
    q_a.push_back(mk(5, 7, 0));
    send_a(16, 1'b0, 1'b0);
    check("bp_first_valid", 32'(a_ov), 32'd1);
    fill(0); frame_v[1] = 3;
    send_a(16, 1'b0, 1'b0);
    check("bp_overrun_pulse", 32'(a_overrun), 32'd1);
    check("bp_held_symbol",   32'(a_sym),     32'd5);
    check("bp_held_valid",    32'(a_ov),      32'd1);
    tick();
    check("bp_overrun_single", 32'(a_overrun), 32'd0);
    a_ready = 1'b1;
    tick();
    check("bp_valid_cleared", 32'(a_ov), 32'd0);

    // frame_sync coinciding with chip_valid at slot 8
    fill(7);
    send_a(8, 1'b0, 1'b0);
    fill(1); frame_v[2] = 6;
    a_thr = 4'd2;
    q_a.push_back(mk(2, 6, 0));
    send_a(16, 1'b0, 1'b1);
    check("sync_latency_valid", 32'(a_ov), 32'd1);
    tick();

    // frame_sync on an idle cycle mid-frame
    fill(7);
    send_a(5, 1'b0, 1'b0);
    a_sync = 1'b1;
    tick();
    a_sync = 1'b0;
    fill(1); frame_v[2] = 6;
    q_a.push_back(mk(2, 6, 0));
    send_a(16, 1'b0, 1'b0);
    tick();

    // Mid-frame reset clears a held result and restarts counting
    a_ready = 1'b0;
    load_t1();
    send_a(16, 1'b0, 1'b0);
    check("pre_reset_valid", 32'(a_ov), 32'd1);
    send_a(5, 1'b0, 1'b0);
    #2 rstb = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(a_ov),      32'd0);
    check("mid_rst_symbol",    32'(a_sym),     32'd0);
    check("mid_rst_peak",      32'(a_peak),    32'd0);
    check("mid_rst_unmet",     32'(a_unmet),   32'd1);
    check("mid_rst_overrun",   32'(a_overrun), 32'd0);
    tick();
    rstb    = 1'b1;
    a_ready = 1'b1;
    tick();
    load_t1();
    q_a.push_back(mk(4, 6, 0));
    send_a(16, 1'b0, 1'b0);
    check("post_rst_latency_valid", 32'(a_ov), 32'd1);

    repeat (4) tick();
    check("a_queue_drained", 32'(q_a.size()), 32'd0);
    check("b_queue_drained", 32'(q_b.size()), 32'd0);
    check("c_queue_drained", 32'(q_c.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
